// File: rtl/quant_pkg.sv
// Shared quantizer definitions: TU-size codes, default widths, beat math.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
package quant_pkg;

    typedef enum logic [1:0] {
        DCT_4  = 2'b00,
        DCT_8  = 2'b01,
        DCT_16 = 2'b10,
        DCT_32 = 2'b11
    } tu_size_e;

    localparam int DEF_LANES  = 4;
    localparam int DEF_DATA_W = 16;

    // Signed width of product and sum; wide enough that nothing wraps before the shift.
    localparam int IW = 33;

    localparam int Q_W   = 16;
    localparam int OFF_W = 28;
    localparam int SH_W  = 5;

    // Holds beat indices up to 32*32 beats, i.e. also covers a single-lane build.
    localparam int CNT_W = 11;

    // Number of valid beats making up one TU of the given size code.
    function automatic logic [CNT_W-1:0] beats_per_tu(input logic [1:0] size, input int lanes);
        int n;
        case (size)
            DCT_4:   n = 4;
            DCT_8:   n = 8;
            DCT_16:  n = 16;
            default: n = 32;
        endcase
        return CNT_W'((n * n) / lanes);
    endfunction

endpackage

// File: rtl/quant_lane.sv
// One coefficient lane: forward quantization or dequantization with saturation.
// Latency: 3 cycles (operand prep, multiply, add/shift/sign/clip), one beat per cycle.
// Backpressure: none; bubbles pass through, output data holds while valid is low.
module quant_lane
    import quant_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic              inverse_i,
    input  logic [Q_W-1:0]    q_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [SH_W-1:0]   shift_i,
    input  logic [DATA_W-1:0] coef_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] coef_o
);

    localparam logic signed [IW-1:0] SAT_MAX =
        $signed({{(IW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [IW-1:0] SAT_MIN =
        $signed({{(IW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

    // Stage 1 state
    logic                     s1_vld_q;
    logic                     s1_neg_q;
    logic signed [DATA_W:0]   s1_opnd_q;
    logic [Q_W-1:0]           s1_q_q;
    logic [OFF_W-1:0]         s1_off_q;
    logic [SH_W-1:0]          s1_sh_q;

    // Stage 2 state
    logic                     s2_vld_q;
    logic                     s2_neg_q;
    logic signed [IW-1:0]     s2_prod_q;
    logic [OFF_W-1:0]         s2_off_q;
    logic [SH_W-1:0]          s2_sh_q;

    // Stage 3 state
    logic                     vld_q;
    logic [DATA_W-1:0]        coef_q;

    // Combinational next-state values
    logic signed [DATA_W:0]   coef_ext;
    logic signed [DATA_W:0]   opnd_d;
    logic                     neg_d;
    logic signed [IW-1:0]     opnd_ext;
    logic signed [IW-1:0]     q_ext;
    logic signed [IW-1:0]     prod_d;
    logic signed [IW-1:0]     off_ext;
    logic signed [IW-1:0]     sum;
    logic signed [IW-1:0]     shifted;
    logic signed [IW-1:0]     res;
    logic [DATA_W-1:0]        coef_d;

    // Operand prep: forward mode works on |c| (17 bits, so -32768 is exact) and remembers the sign.
    always_comb begin
        coef_ext = $signed({coef_i[DATA_W-1], coef_i});
        neg_d    = coef_i[DATA_W-1] & ~inverse_i;
        opnd_d   = neg_d ? -coef_ext : coef_ext;
    end

    // Stage 1 register: operand, sign and the beat's quant parameters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_neg_q  <= 1'b0;
            s1_opnd_q <= '0;
            s1_q_q    <= '0;
            s1_off_q  <= '0;
            s1_sh_q   <= '0;
        end else begin
            s1_vld_q <= valid_i;
            if (valid_i) begin
                s1_neg_q  <= neg_d;
                s1_opnd_q <= opnd_d;
                s1_q_q    <= q_i;
                s1_off_q  <= offset_i;
                s1_sh_q   <= shift_i;
            end
        end
    end

    // Multiply at full intermediate width, both operands sign-extended.
    always_comb begin
        opnd_ext = $signed({{(IW-DATA_W-1){s1_opnd_q[DATA_W]}}, s1_opnd_q});
        q_ext    = $signed({{(IW-Q_W){s1_q_q[Q_W-1]}}, s1_q_q});
        prod_d   = opnd_ext * q_ext;
    end

    // Stage 2 register: product plus the parameters still needed downstream.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q  <= 1'b0;
            s2_neg_q  <= 1'b0;
            s2_prod_q <= '0;
            s2_off_q  <= '0;
            s2_sh_q   <= '0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_neg_q  <= s1_neg_q;
                s2_prod_q <= prod_d;
                s2_off_q  <= s1_off_q;
                s2_sh_q   <= s1_sh_q;
            end
        end
    end

    // Add offset, arithmetic shift, restore sign, then clip to the coefficient range.
    always_comb begin
        off_ext = $signed({{(IW-OFF_W){s2_off_q[OFF_W-1]}}, s2_off_q});
        sum     = s2_prod_q + off_ext;
        shifted = sum >>> s2_sh_q;
        res     = s2_neg_q ? -shifted : shifted;
        coef_d  = res[DATA_W-1:0];
        if (res > SAT_MAX) begin
            coef_d = SAT_MAX[DATA_W-1:0];
        end else if (res < SAT_MIN) begin
            coef_d = SAT_MIN[DATA_W-1:0];
        end
    end

    // Stage 3 register: result only updates on a valid beat, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            coef_q <= '0;
        end else begin
            vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                coef_q <= coef_d;
            end
        end
    end

    assign valid_o = vld_q;
    assign coef_o  = coef_q;

endmodule

// File: rtl/quant_core.sv
// Multi-lane TU quantizer/dequantizer with per-TU parameter latch; coded-block flag under QUANT_CORE_CBF_EN.
// Latency: 3 cycles i_valid to o_valid; o_cbf_valid coincides with the TU's last output beat.
// Backpressure: none; accepts a beat every cycle and bubbles on i_valid propagate to o_valid.
module quant_core
    import quant_pkg::*;
#(
    parameter int LANES  = DEF_LANES,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic                    i_inverse,
    input  logic [1:0]              i_transize,
    input  logic [Q_W-1:0]          i_q_data,
    input  logic [OFF_W-1:0]        i_offset,
    input  logic [SH_W-1:0]         i_shift,
    input  logic [LANES*DATA_W-1:0] i_coef,
    output logic                    o_valid,
    output logic [LANES*DATA_W-1:0] o_coef,
    output logic                    o_cbf,
    output logic                    o_cbf_valid
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] tu_beats;
    logic             first_beat;
    logic             last_beat;

    logic             inv_q;
    logic [1:0]       size_q;
    logic [Q_W-1:0]   qd_q;
    logic [OFF_W-1:0] off_q;
    logic [SH_W-1:0]  sh_q;

    logic             eff_inv;
    logic [1:0]       eff_size;
    logic [Q_W-1:0]   eff_q;
    logic [OFF_W-1:0] eff_off;
    logic [SH_W-1:0]  eff_sh;

    logic [LANES-1:0] lane_vld;

    // Beat 0 uses the live parameter inputs; later beats of the TU reuse the latched copy.
    always_comb begin
        first_beat = (cnt_q == '0);
        eff_inv    = first_beat ? i_inverse  : inv_q;
        eff_size   = first_beat ? i_transize : size_q;
        eff_q      = first_beat ? i_q_data   : qd_q;
        eff_off    = first_beat ? i_offset   : off_q;
        eff_sh     = first_beat ? i_shift    : sh_q;
        tu_beats   = beats_per_tu(eff_size, LANES);
        last_beat  = i_valid && (cnt_q == tu_beats - 1'b1);
        cnt_d      = cnt_q;
        if (i_valid) begin
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        end
    end

    // Beat counter (holds through gaps) and parameter latch on the first beat of each TU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            inv_q  <= 1'b0;
            size_q <= '0;
            qd_q   <= '0;
            off_q  <= '0;
            sh_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (i_valid && first_beat) begin
                inv_q  <= i_inverse;
                size_q <= i_transize;
                qd_q   <= i_q_data;
                off_q  <= i_offset;
                sh_q   <= i_shift;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            quant_lane #(
                .DATA_W (DATA_W)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .valid_i   (i_valid),
                .inverse_i (eff_inv),
                .q_i       (eff_q),
                .offset_i  (eff_off),
                .shift_i   (eff_sh),
                .coef_i    (i_coef[g*DATA_W +: DATA_W]),
                .valid_o   (lane_vld[g]),
                .coef_o    (o_coef[g*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // All lanes run in lockstep, so their valids are identical.
    assign o_valid = &lane_vld;

`ifdef QUANT_CORE_CBF_EN
    logic [2:0] last_pipe_q;
    logic       cbf_acc_q;
    logic       cbf_acc_d;
    logic       beat_nz;
    logic       cbf_pulse;

    // Flag the TU's last output beat; that beat's own lanes are folded in combinationally.
    always_comb begin
        beat_nz   = |o_coef;
        cbf_pulse = o_valid & last_pipe_q[2];
        cbf_acc_d = cbf_acc_q;
        if (o_valid) begin
            cbf_acc_d = cbf_pulse ? 1'b0 : (cbf_acc_q | beat_nz);
        end
        o_cbf_valid = cbf_pulse;
        o_cbf       = cbf_pulse & (cbf_acc_q | beat_nz);
    end

    // Last-beat marker travels alongside the lane pipeline; accumulator clears after each pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pipe_q <= '0;
            cbf_acc_q   <= 1'b0;
        end else begin
            last_pipe_q <= {last_pipe_q[1:0], last_beat};
            cbf_acc_q   <= cbf_acc_d;
        end
    end
`else
    assign o_cbf       = 1'b0;
    assign o_cbf_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quant_core.sv
// Scoreboard bench for quant_core: reference results queued at drive time, compared at output.
// Latency: outputs expected exactly 3 clocks after the capturing edge.
// Backpressure: none; bubbles in the stimulus must reappear on o_valid.
module tb_quant_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_inverse;
    logic [1:0]  i_transize;
    logic [15:0] i_q_data;
    logic [27:0] i_offset;
    logic [4:0]  i_shift;
    logic [63:0] i_coef;
    logic        o_valid;
    logic [63:0] o_coef;
    logic        o_cbf;
    logic        o_cbf_valid;

    quant_core dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_inverse   (i_inverse),
        .i_transize  (i_transize),
        .i_q_data    (i_q_data),
        .i_offset    (i_offset),
        .i_shift     (i_shift),
        .i_coef      (i_coef),
        .o_valid     (o_valid),
        .o_coef      (o_coef),
        .o_cbf       (o_cbf),
        .o_cbf_valid (o_cbf_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] coef;
        bit          last;
        bit          cbf;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    sb_t         e_mon;
    bit          exp_now;
    int          cyc = 0;
    int          n_err = 0;
    int          n_chk = 0;
    bit          mon_en = 1'b0;
    logic [63:0] last_out = '0;

    // stimulus-side parameters and the model's latched per-TU copy
    logic        p_inv, m_inv;
    logic [1:0]  p_size, m_size;
    logic [15:0] p_q, m_q;
    logic [27:0] p_off, m_off;
    logic [4:0]  p_sh, m_sh;
    int          tb_cnt = 0;
    bit          m_acc = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic int tu_beats(input logic [1:0] s);
        case (s)
            2'd0:    return 4;
            2'd1:    return 16;
            2'd2:    return 64;
            default: return 256;
        endcase
    endfunction

    function automatic logic [15:0] ref_q(input logic [15:0] c, input logic inv, input logic [15:0] q,
                                          input logic [27:0] off, input logic [4:0] sh);
        longint cv, qv, ov, v;
        cv = longint'($signed(c));
        qv = longint'($signed(q));
        ov = longint'($signed(off));
        if (inv) begin
            v = (cv * qv + ov) >>> sh;
        end else begin
            v = ((cv < 0 ? -cv : cv) * qv + ov) >>> sh;
            if (cv < 0) v = -v;
        end
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    function automatic logic [15:0] rc();
        int unsigned r;
        logic [15:0] v;
        r = $urandom_range(0, 3);
        case (r)
            0: v = 16'h0000;
            1: begin
                v = 16'($urandom_range(0, 300));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
            2: v = 16'($urandom);
            default: v = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7fff;
        endcase
        return v;
    endfunction

    function automatic logic [63:0] rbeat();
        return {rc(), rc(), rc(), rc()};
    endfunction

    task automatic set_p(input logic inv, input logic [1:0] s, input logic [15:0] q,
                         input logic [27:0] off, input logic [4:0] sh);
        p_inv = inv; p_size = s; p_q = q; p_off = off; p_sh = sh;
    endtask

    task automatic rnd_fwd(input logic [1:0] s);
        logic [4:0] sh;
        sh = 5'($urandom_range(8, 20));
        set_p(1'b0, s, 16'($urandom_range(0, 32767)), 28'($urandom_range(0, (1 << sh) - 1)), sh);
    endtask

    task automatic rnd_inv(input logic [1:0] s);
        set_p(1'b1, s, 16'($urandom), 28'($urandom_range(0, 63)) - 28'd32, 5'($urandom_range(0, 6)));
    endtask

    // Drive one valid beat and queue its expected result (model, or a fixed value when use_exp).
    task automatic send(input logic [63:0] coefs, input bit use_exp, input logic [63:0] exp_v);
        sb_t         e;
        logic [63:0] ev;
        logic [15:0] lane_c;
        @(posedge clk); #1;
        i_valid = 1'b1; i_coef = coefs; i_inverse = p_inv; i_transize = p_size;
        i_q_data = p_q; i_offset = p_off; i_shift = p_sh;
        if (tb_cnt == 0) begin
            m_inv = p_inv; m_size = p_size; m_q = p_q; m_off = p_off; m_sh = p_sh;
        end
        for (int l = 0; l < 4; l++) begin
            lane_c = coefs[l*16 +: 16];
            ev[l*16 +: 16] = ref_q(lane_c, m_inv, m_q, m_off, m_sh);
        end
        if (use_exp) ev = exp_v;
        m_acc = m_acc | (ev != 64'd0);
        tb_cnt++;
        e.last = (tb_cnt == tu_beats(m_size));
        e.cbf  = m_acc;
        e.coef = ev;
        e.cyc  = cyc;
        if (e.last) begin
            tb_cnt = 0;
            m_acc  = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Bubbles: valid low, with junk on every other input.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            i_valid = 1'b0; i_coef = {$urandom, $urandom}; i_inverse = 1'($urandom);
            i_transize = 2'($urandom); i_q_data = 16'($urandom); i_offset = 28'($urandom);
            i_shift = 5'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b0; i_valid = 1'b0;
        sb.delete(); tb_cnt = 0; m_acc = 1'b0; last_out = '0;
        @(negedge clk);
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_coef", o_coef, 64'd0);
        chk("rst_o_cbf", 64'(o_cbf), 64'd0);
        chk("rst_o_cbf_valid", 64'(o_cbf_valid), 64'd0);
        repeat (n) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Output monitor: every cycle, o_valid must match the queue timing; data holds in gaps.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_now = (sb.size() > 0) && (sb[0].cyc + 3 == cyc);
            chk("o_valid", 64'(o_valid), 64'(exp_now));
            if (exp_now) begin
                e_mon = sb.pop_front();
                chk("o_coef", o_coef, e_mon.coef);
                last_out = e_mon.coef;
`ifdef QUANT_CORE_CBF_EN
                chk("o_cbf_valid", 64'(o_cbf_valid), 64'(e_mon.last));
                if (e_mon.last) chk("o_cbf", 64'(o_cbf), 64'(e_mon.cbf));
`endif
            end else begin
                chk("o_coef_hold", o_coef, last_out);
`ifdef QUANT_CORE_CBF_EN
                chk("o_cbf_valid_idle", 64'(o_cbf_valid), 64'd0);
`endif
            end
`ifndef QUANT_CORE_CBF_EN
            chk("o_cbf_tied", 64'(o_cbf), 64'd0);
            chk("o_cbf_valid_tied", 64'(o_cbf_valid), 64'd0);
`endif
        end
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_inverse = 1'b0; i_transize = 2'd0;
        i_q_data = '0; i_offset = '0; i_shift = '0; i_coef = '0;
        set_p(1'b0, 2'd0, 16'd0, 28'd0, 5'd0);
        do_reset(2);
        mon_en = 1'b1;

        // forward 4x4 with the reference vectors
        set_p(1'b0, 2'd0, 16'd26214, 28'd175104, 5'd19);
        send(pk(100, -100, 100, -100), 1'b1, pk(5, -5, 5, -5));
        send(pk(-100, 100, 0, 0), 1'b1, pk(-5, 5, 0, 0));
        send(rbeat(), 1'b0, '0);
        send(rbeat(), 1'b0, '0);
        idle(2);

        // inverse 4x4
        set_p(1'b1, 2'd0, 16'd40, 28'd1, 5'd1);
        send(pk(5, -5, 0, 5), 1'b1, pk(100, -100, 0, 100));
        send(pk(0, 0, 0, 0), 1'b1, pk(0, 0, 0, 0));
        send(pk(-5, 5, -5, 0), 1'b1, pk(-100, 100, -100, 0));
        send(rbeat(), 1'b0, '0);
        idle(1);

        // inverse saturation
        set_p(1'b1, 2'd0, 16'd18432, 28'd1, 5'd1);
        send(pk(32767, -32768, 32767, -32768), 1'b1, pk(32767, -32768, 32767, -32768));
        send(pk(-32768, 32767, 0, 1), 1'b1, pk(-32768, 32767, 0, 9216));
        send(rbeat(), 1'b0, '0);
        send(rbeat(), 1'b0, '0);

        // back-to-back 4x4 TUs: all zero, then a single nonzero lane
        set_p(1'b0, 2'd0, 16'd26214, 28'd175104, 5'd19);
        for (int b = 0; b < 4; b++) send(64'd0, 1'b1, 64'd0);
        send(pk(0, 0, 100, 0), 1'b1, pk(0, 0, 5, 0));
        for (int b = 0; b < 3; b++) send(64'd0, 1'b1, 64'd0);
        idle(3);

        // 8x8 with gaps; parameter inputs change mid-TU and must be ignored
        rnd_fwd(2'd1);
        for (int b = 0; b < 16; b++) begin
            if (b == 5)  p_q = p_q ^ 16'h5a5a;
            if (b == 9)  p_off = p_off + 28'd99999;
            if (b == 11) p_inv = ~p_inv;
            if (b == 13) p_size = 2'd3;
            send(rbeat(), 1'b0, '0);
            idle($urandom_range(0, 2));
        end
        idle(2);

        // 16x16 interrupted by reset after beat 2, then a full 64-beat TU
        rnd_inv(2'd2);
        for (int b = 0; b < 3; b++) send(rbeat(), 1'b0, '0);
        do_reset(3);
        rnd_fwd(2'd2);
        for (int b = 0; b < 64; b++) send(rbeat(), 1'b0, '0);
        idle(2);

        // 32x32 dequantization with occasional gaps
        rnd_inv(2'd3);
        for (int b = 0; b < 256; b++) begin
            send(rbeat(), 1'b0, '0);
            if ($urandom_range(0, 15) == 0) idle(1);
        end

        // a few short TUs with random modes
        for (int t = 0; t < 6; t++) begin
            if (t[0]) rnd_inv(2'd0); else rnd_fwd(2'd0);
            for (int b = 0; b < 4; b++) send(rbeat(), 1'b0, '0);
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
